card_sprite_loader: RTL
=======================

CARD_SPRITE_LOADER -- requirements
Module: card_sprite_loader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 12, pixel color depth (4b R, 4b G, 4b B).
REQ-002 SHALL have parameter ADDR_WIDTH, default 11, sprite RAM address bits; frame = 2**ADDR_WIDTH pixels.
REQ-003 SHALL have parameter SYNC_BYTE, default 8'hA5, frame start marker.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 1_000_000, max idle clocks between bytes inside a frame.
REQ-005 SHALL have port clk, input, 1, single system clock; all logic on rising edge.
REQ-006 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port rx_data, input, 8, received byte; valid only when rx_valid=1.
REQ-008 SHALL have port rx_valid, input, 1, one-cycle strobe per received byte (UART rx_done).
REQ-009 SHALL have port we, output, 1, sprite RAM write enable.
REQ-010 SHALL have port addr_w, output, ADDR_WIDTH, sprite RAM write address.
REQ-011 SHALL have port din, output, DATA_WIDTH, sprite RAM write data.
REQ-012 SHALL have port busy, output, 1, high while a frame is in progress.
REQ-013 SHALL have port done, output, 1, one-cycle pulse after the final pixel write.
REQ-014 SHALL have port err, output, 1, sticky protocol/timeout error flag.

Function
REQ-015 SHALL implement FSM states IDLE, HI, LO; all outputs registered.
REQ-016 IDLE: rx_valid with rx_data==SYNC_BYTE -> HI, pixel index=0, busy=1, err=0; any other byte ignored, no output change.
REQ-017 HI: rx_valid with rx_data[7:4]==0 -> latch rx_data[3:0] as R, go LO.
REQ-018 HI: rx_valid with rx_data[7:4]!=0 -> err=1, busy=0, go IDLE, no write; a SYNC_BYTE in HI is data, hence an error.
REQ-019 LO: rx_valid -> next cycle we=1 for exactly one cycle, addr_w=pixel index, din={R, rx_data[7:4], rx_data[3:0]}; go HI, pixel index+1.
REQ-020 Latency: we asserts exactly 1 clk after the rx_valid carrying the LO byte.
REQ-021 After writing index 2**ADDR_WIDTH-1: the cycle after that we pulse, done=1 for one cycle, busy=0, state IDLE; the index does not wrap into a second frame.
REQ-022 we SHALL never assert outside a LO-byte write; addr_w/din hold last values when we=0.
REQ-023 Timeout: in HI or LO, a counter restarts on every rx_valid; if TIMEOUT_CYCLES clocks pass with no rx_valid -> err=1, busy=0, go IDLE, no write, no done.
REQ-024 The timeout counter SHALL be held at 0 in IDLE; width $clog2(TIMEOUT_CYCLES+1).
REQ-025 If rx_valid and the timeout expiry fall on the same cycle, rx_valid wins (the byte is processed, no error).
REQ-026 err SHALL remain 1 until cleared by the next accepted SYNC_BYTE or reset; done and err never assert in the same cycle.
REQ-027 A partial frame aborted by error leaves already-written pixels in the RAM; no rollback.

Reset
REQ-028 reset_n=0 SHALL asynchronously force state IDLE, we=0, addr_w=0, din=0, busy=0, done=0, err=0, index=0, timeout counter=0.
REQ-029 Reset asserted mid-frame SHALL abort without any further write; after release, the block waits for SYNC_BYTE.

Verification (ADDR_WIDTH=2, TIMEOUT_CYCLES=16 for the bench)
REQ-030 Full frame: A5, 03,4F, 0A,BC, 00,00, 0F,FF -> four we pulses, addr 0..3, din 34F, ABC, 000, FFF; done one cycle after the 4th we; busy low; err=0.
REQ-031 Junk before sync: 12, 34, then a valid frame -> no we until after A5; frame written as in REQ-030.
REQ-032 Bad high byte: A5, 13 -> no we, err=1, busy=0; a following A5 clears err and starts a new frame at addr 0.
REQ-033 Timeout: A5, 03, then 16 idle clocks -> err=1, busy=0, no we; a byte arriving on the expiry cycle -> no error.
REQ-034 Reset mid-frame: A5, 01,23, then reset_n low for 1 clk mid-byte -> all outputs 0 immediately; a subsequent 45,67 without sync produces no we.
REQ-035 Back-to-back rx_valid on consecutive cycles across a full frame -> every pixel written once, correct addresses, single done pulse.

Source files
------------

// File: rtl/card_sprite_loader.sv
// Sprite frame loader: turns a UART byte stream into sprite RAM writes.
// A frame is a SYNC_BYTE followed by 2**ADDR_WIDTH pixels, each sent as
// two bytes: 0x0R then 0xGB. The result is a 12-bit {R,G,B} RAM write.
// Protocol violations and idle gaps inside a frame abort the frame and
// raise a sticky err. The next accepted SYNC_BYTE clears err.
module card_sprite_loader #(
  parameter int          DATA_WIDTH     = 12,
  parameter int          ADDR_WIDTH     = 11,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter int          TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  we,
  output logic [ADDR_WIDTH-1:0] addr_w,
  output logic [DATA_WIDTH-1:0] din,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  // The counter value at which the next idle clock is the TIMEOUT_CYCLES-th one.
  localparam logic [TW-1:0]         TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HI   = 2'd1,
    LO   = 2'd2
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] idx;
  logic [3:0]            red;
  logic [TW-1:0]         tcnt;
  // Set on the final pixel write; done fires from it on the next clock.
  logic                  fin_pend;

  // Assemble one RAM word from the latched red nibble and the green/blue byte.
  function automatic logic [DATA_WIDTH-1:0] pack_pixel(input logic [3:0] r,
                                                       input logic [7:0] gb);
    pack_pixel = DATA_WIDTH'({r, gb});
  endfunction

  // Frame parser FSM with its timeout counter and all registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      idx      <= '0;
      red      <= '0;
      tcnt     <= '0;
      fin_pend <= 1'b0;
      we       <= 1'b0;
      addr_w   <= '0;
      din      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      we       <= 1'b0;
      done     <= 1'b0;
      fin_pend <= 1'b0;

      // Completion handshake one clock after the last write. A sync byte
      // arriving on this same clock re-raises busy in the IDLE branch below.
      if (fin_pend) begin
        done <= 1'b1;
        busy <= 1'b0;
      end

      case (state)
        IDLE: begin
          tcnt <= '0;
          if (rx_valid && (rx_data == SYNC_BYTE)) begin
            state <= HI;
            idx   <= '0;
            busy  <= 1'b1;
            err   <= 1'b0;
          end
        end

        HI: begin
          if (rx_valid) begin
            tcnt <= '0;
            if (rx_data[7:4] == 4'h0) begin
              red   <= rx_data[3:0];
              state <= LO;
            end else begin
              // Upper nibble must be zero; this includes a stray sync byte.
              err   <= 1'b1;
              busy  <= 1'b0;
              state <= IDLE;
            end
          end else if (tcnt == TMO_LAST) begin
            err   <= 1'b1;
            busy  <= 1'b0;
            tcnt  <= '0;
            state <= IDLE;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end

        LO: begin
          if (rx_valid) begin
            tcnt   <= '0;
            we     <= 1'b1;
            addr_w <= idx;
            din    <= pack_pixel(red, rx_data);
            if (idx == LAST_IDX) begin
              // Frame complete. The index is left at the last value and
              // never wraps into a second frame.
              fin_pend <= 1'b1;
              state    <= IDLE;
            end else begin
              idx   <= idx + 1'b1;
              state <= HI;
            end
          end else if (tcnt == TMO_LAST) begin
            err   <= 1'b1;
            busy  <= 1'b0;
            tcnt  <= '0;
            state <= IDLE;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          tcnt  <= '0;
        end
      endcase
    end
  end

endmodule
